bip_acc_unit: RTL and testbench
===============================

# bip_acc_unit

Parametrised accumulator execution unit for the BIP accumulator CPU datapath: operand selection, ALU and a registered accumulator with status flags in one clocked block. Sits between the decode/control unit (which drives the select, op and write-enable lines) and data memory / sign-extension unit (which supply operands). Unlike a purely combinational source-select stage, the accumulator is a real register with an explicit write enable, a stall input and flags. An optional saturating-arithmetic mode is available.

## Interface
Parameters:
- NBITS_D, 16, datapath / accumulator width (≥ 4)
- NBITS_OP, 3, ALU opcode width (fixed encoding below; values ≥ 8 unused)

Ports:
- i_clock  in  1  single clock, rising-edge
- i_reset  in  1  synchronous, active-high reset
- i_SelA  in  2  ACC source: 00 i_OutData, 01 i_ExtensionData, 10 ALU result, 11 hold
- i_SelB  in  1  ALU operand B: 0 i_OutData, 1 i_ExtensionData
- i_Op  in  NBITS_OP  ALU operation
- i_WrAcc  in  1  accumulator write enable
- i_Stall  in  1  freeze all registers
- i_OutData  in  NBITS_D  data memory read value
- i_ExtensionData  in  NBITS_D  sign-extended immediate
- o_ACC  out  NBITS_D  registered accumulator
- o_SelB  out  NBITS_D  selected operand B (combinational)
- o_ALU  out  NBITS_D  ALU result (combinational)
- o_Zero, o_Neg, o_Carry, o_Ovf  out  1 each  registered flags

## Operation
- Operand A of the ALU is always the registered ACC; operand B is o_SelB.
- i_Op: 000 ADD A+B; 001 SUB A−B; 010 AND; 011 OR; 100 XOR; 101 PASSB; 110 SHL1 A (LSB 0); 111 SRA1 A (MSB replicated). Undefined codes (NBITS_OP>3) → result = A, no flag side effects beyond ordinary ACC write.
- ADD/SUB computed in NBITS_D+1 bits. Carry = bit NBITS_D of A+B; for SUB carry = NOT borrow (A ≥ B unsigned). Ovf = signed two's-complement overflow. SHL1: carry = A[MSB]. All other ops: carry = 0, ovf = 0.
- ACC write occurs on a rising edge when i_WrAcc=1, i_Stall=0, i_SelA≠11. i_SelA=11 with i_WrAcc=1 is a legal no-op (ACC and flags hold).
- On every ACC write: o_Zero = (new ACC == 0), o_Neg = new ACC[MSB]. o_Carry/o_Ovf = ALU carry/ovf when i_SelA=10, else cleared to 0.
- No write → ACC and all four flags hold.
- i_Stall=1 overrides i_WrAcc; i_reset overrides everything.

## Timing
- Reset (synchronous, sampled at edge with i_reset=1): o_ACC=0, o_Zero=0, o_Neg=0, o_Carry=0, o_Ovf=0. Combinational outputs follow from reset ACC (o_ALU valid next cycle from ACC=0).
- o_SelB, o_ALU: zero-cycle combinational from inputs and current ACC.
- ACC/flags: 1-cycle latency; value written at edge N visible after edge N; ALU in cycle N+1 uses it as operand A (back-to-back accumulate needs no bubble).
- Reset asserted mid-sequence (with i_WrAcc=1, i_Stall=1) → reset wins at that edge.
- No combinational path from o_ACC back into itself other than through the register.

## Configuration
- Macro BIP_ACC_SAT_EN.
- Defined: ADD and SUB saturate on signed overflow — positive overflow → 0111…1, negative → 1000…0; o_Ovf still set to 1 on the saturating write; carry computed from unsaturated sum. Other ops unaffected.
- Undefined: ADD/SUB wrap modulo 2^NBITS_D; o_Ovf reports overflow only.

## Test plan
- Reset then hold: assert i_reset 2 cycles with i_WrAcc=1, i_SelA=00, i_OutData=16'h1234 → o_ACC=0, all flags 0; release with i_WrAcc=0 → ACC stays 0.
- Load and accumulate: load i_OutData=16'h0005 (SelA=00), then ADD with SelB=1, i_ExtensionData=16'h0003, SelA=10 for two consecutive cycles → ACC 5, 8, 11; Zero=0, Neg=0, Carry=0.
- Subtract to zero/borrow: ACC=16'h0004, SUB B=16'h0004 → ACC=0, Zero=1, Carry=1; then SUB B=1 → ACC=16'hFFFF, Neg=1, Carry=0.
- Overflow: ACC=16'h7FFF, ADD B=1 → without BIP_ACC_SAT_EN ACC=16'h8000, Ovf=1, Neg=1; with it ACC=16'h7FFF, Ovf=1, Neg=0.
- Stall and hold: ACC=16'h00AA, i_Stall=1 with i_WrAcc=1, SelA=01, ext=16'h5555 → ACC and flags unchanged; SelA=11, i_WrAcc=1 → unchanged; drop stall with SelA=01 → ACC=16'h5555, Carry=Ovf=0.
- Shifts: ACC=16'h8001, SHL1 → ACC=16'h0002, Carry=1; ACC=16'h8000, SRA1 → ACC=16'hC000, Neg=1, Carry=0.

Source files
------------

// File: rtl/bip_acc_unit_if.sv
// Bus bundle for the BIP accumulator execution unit.
// The control/memory side uses the master modport, the unit uses slave.
interface bip_acc_unit_if #(
    parameter int NBITS_D  = 16,
    parameter int NBITS_OP = 3
);
    logic [1:0]          i_SelA;
    logic                i_SelB;
    logic [NBITS_OP-1:0] i_Op;
    logic                i_WrAcc;
    logic                i_Stall;
    logic [NBITS_D-1:0]  i_OutData;
    logic [NBITS_D-1:0]  i_ExtensionData;
    logic [NBITS_D-1:0]  o_ACC;
    logic [NBITS_D-1:0]  o_SelB;
    logic [NBITS_D-1:0]  o_ALU;
    logic                o_Zero;
    logic                o_Neg;
    logic                o_Carry;
    logic                o_Ovf;

    modport master (
        output i_SelA, i_SelB, i_Op, i_WrAcc, i_Stall, i_OutData, i_ExtensionData,
        input  o_ACC, o_SelB, o_ALU, o_Zero, o_Neg, o_Carry, o_Ovf
    );

    modport slave (
        input  i_SelA, i_SelB, i_Op, i_WrAcc, i_Stall, i_OutData, i_ExtensionData,
        output o_ACC, o_SelB, o_ALU, o_Zero, o_Neg, o_Carry, o_Ovf
    );
endinterface

// File: rtl/bip_acc_unit.sv
// BIP accumulator execution unit: operand-B select, ALU, registered
// accumulator and Zero/Neg/Carry/Ovf flags.
// Optional feature: define BIP_ACC_SAT_EN to make ADD/SUB saturate on
// signed overflow instead of wrapping.
module bip_acc_unit #(
    parameter int NBITS_D  = 16,
    parameter int NBITS_OP = 3
) (
    input  logic              i_clock,
    input  logic              i_reset,
    bip_acc_unit_if.slave     bus
);
    localparam int MSB = NBITS_D - 1;

    logic [NBITS_D-1:0] acc_q, acc_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;

    logic [NBITS_D-1:0] opb_w;
    logic [NBITS_D:0]   sum_w, diff_w;
    logic               add_ovf_w, sub_ovf_w;
    logic [NBITS_D-1:0] shl_w, sra_w;
    logic [NBITS_D-1:0] alu_res;
    logic               alu_carry, alu_ovf;
    logic               wr_en_w;

    // Operand B is picked by the decoder; operand A is always the accumulator.
    assign opb_w = bus.i_SelB ? bus.i_ExtensionData : bus.i_OutData;

    // Widen by one bit so the carry-out / borrow falls out of the adder.
    assign sum_w  = {1'b0, acc_q} + {1'b0, opb_w};
    assign diff_w = {1'b0, acc_q} - {1'b0, opb_w};

    // Signed overflow: operand signs vs. result sign.
    assign add_ovf_w = (acc_q[MSB] == opb_w[MSB]) && (sum_w[MSB]  != acc_q[MSB]);
    assign sub_ovf_w = (acc_q[MSB] != opb_w[MSB]) && (diff_w[MSB] != acc_q[MSB]);

    // One-bit shifts wired bit by bit.
    assign shl_w[0]   = 1'b0;
    assign sra_w[MSB] = acc_q[MSB];
    for (genvar gi = 1; gi < NBITS_D; gi++) begin : g_shift
        assign shl_w[gi]   = acc_q[gi-1];
        assign sra_w[gi-1] = acc_q[gi];
    end

`ifdef BIP_ACC_SAT_EN
    // On overflow the true result lies beyond the rail on the side of A's sign.
    logic [NBITS_D-1:0] sat_w;
    assign sat_w = acc_q[MSB] ? {1'b1, {(NBITS_D-1){1'b0}}} : {1'b0, {(NBITS_D-1){1'b1}}};
`endif

    // ALU result and its carry/overflow side outputs.
    always_comb begin
        alu_res   = acc_q;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (bus.i_Op)
            NBITS_OP'(0): begin
                alu_res   = sum_w[MSB:0];
                alu_carry = sum_w[NBITS_D];
                alu_ovf   = add_ovf_w;
`ifdef BIP_ACC_SAT_EN
                if (add_ovf_w) alu_res = sat_w;
`endif
            end
            NBITS_OP'(1): begin
                alu_res   = diff_w[MSB:0];
                alu_carry = ~diff_w[NBITS_D];   // carry = no borrow
                alu_ovf   = sub_ovf_w;
`ifdef BIP_ACC_SAT_EN
                if (sub_ovf_w) alu_res = sat_w;
`endif
            end
            NBITS_OP'(2): alu_res = acc_q & opb_w;
            NBITS_OP'(3): alu_res = acc_q | opb_w;
            NBITS_OP'(4): alu_res = acc_q ^ opb_w;
            NBITS_OP'(5): alu_res = opb_w;
            NBITS_OP'(6): begin
                alu_res   = shl_w;
                alu_carry = acc_q[MSB];
            end
            NBITS_OP'(7): alu_res = sra_w;
            default:      alu_res = acc_q;
        endcase
    end

    // SelA=11 is a legal no-op even with the write enable high.
    assign wr_en_w = bus.i_WrAcc && !bus.i_Stall && (bus.i_SelA != 2'b11);

    // Next accumulator value and flags for a write cycle.
    always_comb begin
        acc_d   = acc_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (wr_en_w) begin
            case (bus.i_SelA)
                2'b00:   acc_d = bus.i_OutData;
                2'b01:   acc_d = bus.i_ExtensionData;
                default: acc_d = alu_res;
            endcase
            zero_d  = (acc_d == '0);
            neg_d   = acc_d[MSB];
            carry_d = (bus.i_SelA == 2'b10) ? alu_carry : 1'b0;
            ovf_d   = (bus.i_SelA == 2'b10) ? alu_ovf   : 1'b0;
        end
    end

    // Accumulator and flag registers; reset wins over stall and write.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.o_ACC   = acc_q;
    assign bus.o_SelB  = opb_w;
    assign bus.o_ALU   = alu_res;
    assign bus.o_Zero  = zero_q;
    assign bus.o_Neg   = neg_q;
    assign bus.o_Carry = carry_q;
    assign bus.o_Ovf   = ovf_q;
endmodule

// File: tb/tb_bip_acc_unit.sv
// Testbench for bip_acc_unit: directed scenarios followed by random steps,
// all checked against an arithmetic reference model.
module tb_bip_acc_unit;
    localparam int N = 16;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                           OP_XOR = 3'd4, OP_PASSB = 3'd5, OP_SHL = 3'd6, OP_SRA = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bip_acc_unit_if #(.NBITS_D(N), .NBITS_OP(3)) bus ();

    bip_acc_unit #(.NBITS_D(N), .NBITS_OP(3)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [N-1:0] m_acc;
    logic         m_z, m_n, m_c, m_v;
    bit           m_valid = 1'b0;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference ALU using integer arithmetic on signed/unsigned values.
    task automatic alu_model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op,
                             output logic [N-1:0] r, output logic c, output logic v);
        longint ua, ub, sa, sb, s;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        r = a;
        case (op)
            OP_ADD, OP_SUB: begin
                if (op == OP_ADD) begin
                    s = sa + sb;
                    c = (ua + ub) > 65535;
                    r = N'(ua + ub);
                end else begin
                    s = sa - sb;
                    c = (ua >= ub);
                    r = N'(ua - ub);
                end
                v = (s > 32767) || (s < -32768);
`ifdef BIP_ACC_SAT_EN
                if (v) r = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
            end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_PASSB: r = b;
            OP_SHL: begin
                r = N'(ua * 2);
                c = (ua >= 32768);
            end
            OP_SRA:   r = N'(sa >>> 1);
            default:  r = a;
        endcase
    endtask

    // Drive one cycle, check combinational outputs, clock it, check registers.
    task automatic step(input string tag, input logic rst_v, input logic [1:0] sel_a,
                        input logic sel_b, input logic [2:0] op, input logic wr,
                        input logic st, input logic [N-1:0] od, input logic [N-1:0] ed);
        logic [N-1:0] b_exp, r, nv;
        logic c, v;
        rst                 = rst_v;
        bus.i_SelA          = sel_a;
        bus.i_SelB          = sel_b;
        bus.i_Op            = op;
        bus.i_WrAcc         = wr;
        bus.i_Stall         = st;
        bus.i_OutData       = od;
        bus.i_ExtensionData = ed;
        #1;
        b_exp = sel_b ? ed : od;
        alu_model(m_acc, b_exp, op, r, c, v);
        if (m_valid) begin
            check({tag, ".selb"}, bus.o_SelB, b_exp);
            check({tag, ".alu"},  bus.o_ALU,  r);
        end
        if (rst_v) begin
            m_acc = '0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
            m_valid = 1'b1;
        end else if (wr && !st && sel_a != 2'b11) begin
            nv = (sel_a == 2'b00) ? od : (sel_a == 2'b01) ? ed : r;
            m_acc = nv;
            m_z = (nv == 0);
            m_n = nv[N-1];
            m_c = (sel_a == 2'b10) ? c : 1'b0;
            m_v = (sel_a == 2'b10) ? v : 1'b0;
        end
        @(posedge clk);
        #1;
        $display("[TB] %s acc=%h z=%0b n=%0b c=%0b v=%0b", tag, bus.o_ACC,
                 bus.o_Zero, bus.o_Neg, bus.o_Carry, bus.o_Ovf);
        check({tag, ".acc"},   bus.o_ACC,        m_acc);
        check({tag, ".zero"},  N'(bus.o_Zero),   N'(m_z));
        check({tag, ".neg"},   N'(bus.o_Neg),    N'(m_n));
        check({tag, ".carry"}, N'(bus.o_Carry),  N'(m_c));
        check({tag, ".ovf"},   N'(bus.o_Ovf),    N'(m_v));
    endtask

    // Directed expectations written as literal values from the scenario list.
    task automatic expect_state(input string tag, input logic [N-1:0] acc,
                                input logic z, input logic n, input logic c, input logic v);
        check({tag, ".kacc"},   bus.o_ACC,       acc);
        check({tag, ".kzero"},  N'(bus.o_Zero),  N'(z));
        check({tag, ".kneg"},   N'(bus.o_Neg),   N'(n));
        check({tag, ".kcarry"}, N'(bus.o_Carry), N'(c));
        check({tag, ".kovf"},   N'(bus.o_Ovf),   N'(v));
    endtask

    function automatic logic [N-1:0] rand_data();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            4:       return 16'h0001;
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        rst = 0;
        bus.i_SelA = 0; bus.i_SelB = 0; bus.i_Op = 0; bus.i_WrAcc = 0;
        bus.i_Stall = 0; bus.i_OutData = 0; bus.i_ExtensionData = 0;
        m_acc = '0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;

        // Reset with a pending write, then release with no write
        step("rst0", 1, 2'b00, 0, OP_ADD, 1, 0, 16'h1234, 16'h0000);
        step("rst1", 1, 2'b00, 0, OP_ADD, 1, 0, 16'h1234, 16'h0000);
        expect_state("rst", 16'h0000, 0, 0, 0, 0);
        step("idle", 0, 2'b00, 0, OP_ADD, 0, 0, 16'h1234, 16'h0000);
        expect_state("idle", 16'h0000, 0, 0, 0, 0);

        // Load and back-to-back accumulate
        step("ld5",  0, 2'b00, 0, OP_ADD, 1, 0, 16'h0005, 16'h0000);
        expect_state("ld5", 16'h0005, 0, 0, 0, 0);
        step("add1", 0, 2'b10, 1, OP_ADD, 1, 0, 16'h0000, 16'h0003);
        expect_state("add1", 16'h0008, 0, 0, 0, 0);
        step("add2", 0, 2'b10, 1, OP_ADD, 1, 0, 16'h0000, 16'h0003);
        expect_state("add2", 16'h000B, 0, 0, 0, 0);

        // Subtract to zero, then borrow
        step("ld4",  0, 2'b00, 0, OP_ADD, 1, 0, 16'h0004, 16'h0000);
        step("sub0", 0, 2'b10, 1, OP_SUB, 1, 0, 16'h0000, 16'h0004);
        expect_state("sub0", 16'h0000, 1, 0, 1, 0);
        step("subb", 0, 2'b10, 1, OP_SUB, 1, 0, 16'h0000, 16'h0001);
        expect_state("subb", 16'hFFFF, 0, 1, 0, 0);

        // Signed overflow on ADD
        step("ld7f", 0, 2'b00, 0, OP_ADD, 1, 0, 16'h7FFF, 16'h0000);
        step("ovf",  0, 2'b10, 1, OP_ADD, 1, 0, 16'h0000, 16'h0001);
`ifdef BIP_ACC_SAT_EN
        expect_state("ovf", 16'h7FFF, 0, 0, 0, 1);
`else
        expect_state("ovf", 16'h8000, 0, 1, 0, 1);
`endif

        // Stall and SelA=11 hold, then release
        step("ldaa",  0, 2'b00, 0, OP_ADD, 1, 0, 16'h00AA, 16'h0000);
        step("stall", 0, 2'b01, 1, OP_ADD, 1, 1, 16'h0000, 16'h5555);
        expect_state("stall", 16'h00AA, 0, 0, 0, 0);
        step("hold",  0, 2'b11, 1, OP_ADD, 1, 0, 16'h0000, 16'h5555);
        expect_state("hold", 16'h00AA, 0, 0, 0, 0);
        step("ld55",  0, 2'b01, 1, OP_ADD, 1, 0, 16'h0000, 16'h5555);
        expect_state("ld55", 16'h5555, 0, 0, 0, 0);

        // Shifts
        step("ld81",  0, 2'b00, 0, OP_ADD, 1, 0, 16'h8001, 16'h0000);
        step("shl",   0, 2'b10, 0, OP_SHL, 1, 0, 16'h0000, 16'h0000);
        expect_state("shl", 16'h0002, 0, 0, 1, 0);
        step("ld80",  0, 2'b00, 0, OP_ADD, 1, 0, 16'h8000, 16'h0000);
        step("sra",   0, 2'b10, 0, OP_SRA, 1, 0, 16'h0000, 16'h0000);
        expect_state("sra", 16'hC000, 0, 1, 0, 0);

        // Reset mid-sequence with write and stall asserted
        step("midrst", 1, 2'b10, 1, OP_ADD, 1, 1, 16'h1111, 16'h2222);
        expect_state("midrst", 16'h0000, 0, 0, 0, 0);

        // Random operation mix against the model
        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i),
                 ($urandom_range(0, 99) == 0),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 4) == 0),
                 rand_data(), rand_data());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always ends on its own
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
